sp1_ram_dp: RTL and testbench

Parametrised simple-dual-port synchronous RAM. It is the next-generation replacement for the fixed 64x32 single-port sp1_ram used by the stgpm core. It adds:
- independent write and read ports
- per-byte write enables
- selectable read-during-write behaviour
- a hardware clear engine that zeroes the array after reset

---
 rtl/sp1_ram_dp.sv | 114 +++++++++++
 tb/tb_sp1_ram_dp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sp1_ram_dp.sv
// sp1_ram_dp: simple-dual-port synchronous RAM with per-byte write enables,
// selectable read-during-write result and a post-reset clear engine.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_CLEAR| clear engine zeroes mem[clr_ptr] each cycle; ports ignored
// ST_READY| normal operation; write and read ports active
module sp1_ram_dp #(
    parameter int AW         = 6,
    parameter int DW         = 32,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            busy,
    input  logic            wcs,
    input  logic [DW/8-1:0] wbe,
    input  logic [AW-1:0]   wadr,
    input  logic [DW-1:0]   wdin,
    input  logic            rcs,
    input  logic [AW-1:0]   radr,
    output logic [DW-1:0]   rdout,
    output logic            rvalid
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   clr_ptr;
    logic            clr_last;
    logic            wr_en;
    logic            rd_en;
    logic            rdw_hit;
    logic [DW-1:0]   rd_word;
    logic [DW-1:0]   rd_merged;
    logic [DW-1:0]   mem [DEPTH];

    assign busy     = (state == ST_CLEAR);
    assign clr_last = (clr_ptr == AW'(DEPTH - 1));

    // A write at the reset edge is dropped even in READY, where busy is low.
    // An X on wcs makes wr_en X, which the if() below treats as false.
    assign wr_en   = wcs && !busy && !rst;
    assign rd_en   = rcs && !busy;
    assign rdw_hit = wr_en && (wadr == radr);
    assign rd_word = mem[radr];

    // State register; reset always restarts the clear sequence from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (CLR_ON_RST != 0) state <= ST_CLEAR;
            else                 state <= ST_READY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR on the edge that writes the last word.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (clr_last) state_nxt = ST_READY;
            ST_READY: state_nxt = ST_READY;
            default:  state_nxt = ST_READY;
        endcase
    end

    // Clear pointer advances once per clear write.
    always_ff @(posedge clk) begin
        if (rst)       clr_ptr <= '0;
        else if (busy) clr_ptr <= clr_ptr + 1'b1;
    end

    // Memory array: clear engine has priority, otherwise byte-lane writes.
    always_ff @(posedge clk) begin
        if (busy && !rst) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) mem[wadr][8*i +: 8] <= wdin[8*i +: 8];
            end
        end
    end

    // Write-first view of the addressed word for same-address collisions.
    always_comb begin
        rd_merged = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (rdw_hit && wbe[i]) rd_merged[8*i +: 8] = wdin[8*i +: 8];
        end
    end

    // Registered read port; rdout holds between reads, rvalid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdout  <= '0;
            rvalid <= 1'b0;
        end else if (rd_en) begin
            rdout  <= (RDW_MODE != 0) ? rd_merged : rd_word;
            rvalid <= 1'b1;
        end else begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sp1_ram_dp.sv
// Directed bench for sp1_ram_dp: old-data, new-data and no-clear variants.
module tb_sp1_ram_dp;

    logic        clk = 1'b0;
    logic        rst;
    logic        wcs;
    logic [3:0]  wbe;
    logic [5:0]  wadr;
    logic [31:0] wdin;
    logic        rcs;
    logic [5:0]  radr;

    logic        busy0, busy1, busy2;
    logic [31:0] rdout0, rdout1, rdout2;
    logic        rvalid0, rvalid1, rvalid2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sp1_ram_dp #(.AW(6), .DW(32), .RDW_MODE(0), .CLR_ON_RST(1)) u_dut0 (
        .clk(clk), .rst(rst), .busy(busy0), .wcs(wcs), .wbe(wbe), .wadr(wadr),
        .wdin(wdin), .rcs(rcs), .radr(radr), .rdout(rdout0), .rvalid(rvalid0));

    sp1_ram_dp #(.AW(6), .DW(32), .RDW_MODE(1), .CLR_ON_RST(1)) u_dut1 (
        .clk(clk), .rst(rst), .busy(busy1), .wcs(wcs), .wbe(wbe), .wadr(wadr),
        .wdin(wdin), .rcs(rcs), .radr(radr), .rdout(rdout1), .rvalid(rvalid1));

    sp1_ram_dp #(.AW(6), .DW(32), .RDW_MODE(0), .CLR_ON_RST(0)) u_dut2 (
        .clk(clk), .rst(rst), .busy(busy2), .wcs(wcs), .wbe(wbe), .wadr(wadr),
        .wdin(wdin), .rcs(rcs), .radr(radr), .rdout(rdout2), .rvalid(rvalid2));

    typedef struct {
        logic        wcs;
        logic [3:0]  wbe;
        logic [5:0]  wadr;
        logic [31:0] wdin;
        logic        rcs;
        logic [5:0]  radr;
        logic [31:0] exp_rdout0;
        logic [31:0] exp_rdout1;
        logic        exp_rvalid;
    } vec_t;

    vec_t vecs[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        wcs  = 1'b0;
        rcs  = 1'b0;
        wbe  = 4'h0;
        wadr = '0;
        wdin = '0;
        radr = '0;
    endtask

    // Counts edges after rst release until busy0 drops, bounded.
    task automatic count_busy(output int n, input bit gate_check);
        int bad;
        bad = 0;
        n   = 0;
        while (busy0 === 1'b1 && n < 200) begin
            tick();
            n++;
            if (gate_check && (rvalid0 !== 1'b0 || rdout0 !== 32'h0)) bad++;
        end
        if (gate_check) check("busy_gating_errors", 32'(bad), 32'd0);
    endtask

    initial begin
        int n;

        vecs[0]  = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h00, 32'h00000000, 32'h00000000, 1'b1};
        vecs[1]  = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h3f, 32'h00000000, 32'h00000000, 1'b1};
        vecs[2]  = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b0, 6'h00, 32'h00000000, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 4'hf, 6'h05, 32'h12345678, 1'b0, 6'h00, 32'h00000000, 32'h00000000, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h05, 32'h12345678, 32'h12345678, 1'b1};
        vecs[5]  = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b0, 6'h00, 32'h12345678, 32'h12345678, 1'b0};
        vecs[6]  = '{1'b1, 4'h5, 6'h05, 32'hAABBCCDD, 1'b0, 6'h00, 32'h12345678, 32'h12345678, 1'b0};
        vecs[7]  = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h05, 32'h12BB56DD, 32'h12BB56DD, 1'b1};
        vecs[8]  = '{1'b1, 4'hf, 6'h05, 32'hFFFFFFFF, 1'b1, 6'h05, 32'h12BB56DD, 32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h05, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{1'b1, 4'h0, 6'h0a, 32'h11111111, 1'b1, 6'h20, 32'h00000000, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h0a, 32'h00000000, 32'h00000000, 1'b1};
        vecs[12] = '{1'b1, 4'hf, 6'h07, 32'hCAFEF00D, 1'b1, 6'h08, 32'h00000000, 32'h00000000, 1'b1};
        vecs[13] = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h07, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
        vecs[14] = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h05, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[15] = '{1'b1, 4'h8, 6'h07, 32'h5A000000, 1'b1, 6'h07, 32'hCAFEF00D, 32'h5AFEF00D, 1'b1};
        vecs[16] = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h07, 32'h5AFEF00D, 32'h5AFEF00D, 1'b1};
        vecs[17] = '{1'bx, 4'hf, 6'h07, 32'h0,        1'b0, 6'h00, 32'h5AFEF00D, 32'h5AFEF00D, 1'b0};
        vecs[18] = '{1'b0, 4'h0, 6'h00, 32'h0,        1'b1, 6'h07, 32'h5AFEF00D, 32'h5AFEF00D, 1'b1};

        // Reset for 5 cycles, then clear with port traffic that must be ignored.
        idle();
        rst = 1'b1;
        repeat (5) tick();
        check("rst_busy0", 32'(busy0), 32'd1);
        check("rst_busy2", 32'(busy2), 32'd0);
        check("rst_rdout0", rdout0, 32'h0);
        check("rst_rvalid0", 32'(rvalid0), 32'd0);

        rst  = 1'b0;
        wcs  = 1'b1;
        wbe  = 4'hf;
        wadr = 6'h10;
        wdin = 32'hDEADBEEF;
        rcs  = 1'b1;
        radr = 6'h10;
        count_busy(n, 1'b1);
        check("clear_busy_cycles", 32'(n), 32'd64);
        check("clear_busy1_low", 32'(busy1), 32'd0);

        // Read of 0x10 after the clear: the gated write must not have landed.
        idle();
        rcs  = 1'b1;
        radr = 6'h10;
        tick();
        check("gated_write_rdout", rdout0, 32'h0);
        check("gated_write_rvalid", 32'(rvalid0), 32'd1);

        for (int i = 0; i < 19; i++) begin
            wcs  = vecs[i].wcs;
            wbe  = vecs[i].wbe;
            wadr = vecs[i].wadr;
            wdin = vecs[i].wdin;
            rcs  = vecs[i].rcs;
            radr = vecs[i].radr;
            tick();
            check($sformatf("vec%0d_rdout_old", i), rdout0, vecs[i].exp_rdout0);
            check($sformatf("vec%0d_rdout_new", i), rdout1, vecs[i].exp_rdout1);
            check($sformatf("vec%0d_rvalid", i), 32'(rvalid0), 32'(vecs[i].exp_rvalid));
            check($sformatf("vec%0d_rvalid_new", i), 32'(rvalid1), 32'(vecs[i].exp_rvalid));
        end

        // Write at the reset edge in READY is dropped (visible on the no-clear variant).
        idle();
        wcs  = 1'b1;
        wbe  = 4'hf;
        wadr = 6'h30;
        wdin = 32'h11223344;
        tick();
        rst  = 1'b1;
        wdin = 32'h99999999;
        tick();
        check("rst_edge_rdout0", rdout0, 32'h0);
        check("rst_edge_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_edge_busy0", 32'(busy0), 32'd1);
        rst  = 1'b0;
        idle();
        rcs  = 1'b1;
        radr = 6'h30;
        tick();
        check("rst_edge_write_dropped", rdout2, 32'h11223344);
        check("noclear_rvalid", 32'(rvalid2), 32'd1);
        check("clear_gates_read", 32'(rvalid0), 32'd0);

        // Reassert reset at clear cycle 20: the full 64-cycle clear restarts.
        rcs = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midclear_rst_busy", 32'(busy0), 32'd1);
        count_busy(n, 1'b0);
        check("midclear_busy_cycles", 32'(n), 32'd64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
